// File: rtl/avmm_pio_pkg.sv
// Shared definitions for the Avalon-MM PIO initiator: FSM state encoding,
// PIO register map and default widths.
package avmm_pio_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    // PIO slave register map; the remaining addresses are reserved.
    localparam logic [1:0] ADDR_CTRL = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/avmm_pio_master_if.sv
// Command stream, Avalon-MM initiator and response stream signals of the
// PIO initiator. The master modport is the initiator's own view; the slave
// modport is the view of whatever drives commands and models the slave.
interface avmm_pio_master_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_wdata;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
        output cmd_ready,
        output address, read, write, writedata,
        input  waitrequest, readdata,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_wdata,
        input  cmd_ready,
        input  address, read, write, writedata,
        output waitrequest, readdata,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/avmm_watchdog.sv
// Saturating stall counter. Counts cycles with enable high, clears on clear.
// expired flags the cycle in which the LIMIT-th consecutive enabled cycle
// is being counted, so the caller can abort on the following edge.
module avmm_watchdog
    import avmm_pio_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = cnt_width(LIMIT);

    logic [CNT_W-1:0] count_q;

    // Stall count: clear wins, saturates at LIMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CNT_W'(LIMIT))) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = enable && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/avmm_pio_master.sv
// Avalon-MM initiator for the PIO slave. Accepts one read/write command at a
// time, runs a single-beat transfer honouring waitrequest and a fixed read
// latency, and returns the completion on a valid/ready response port.
// Optional waitrequest timeout: define AVMM_PIO_MASTER_TIMEOUT_EN.
module avmm_pio_master
    import avmm_pio_pkg::*;
#(
    parameter int unsigned ADDR_W         = 2,
    parameter int unsigned DATA_W         = DATA_W_DEFAULT,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               reset,
    avmm_pio_master_if.master bus
);

    localparam int unsigned LAT_MAX  = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam int unsigned LAT_W    = cnt_width(LAT_MAX);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT_MAX);

    if (READ_LATENCY > 7) begin : g_bad_latency
        $error("READ_LATENCY must be in 0..7");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              is_write_q;
    logic              read_q;
    logic              write_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              timeout;

`ifdef AVMM_PIO_MASTER_TIMEOUT_EN
    // Counter is held clear outside BUS, so it restarts on every BUS entry.
    avmm_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != BUS),
        .enable  ((state_q == BUS) && bus.waitrequest),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Transfer sequencer; every bus-facing output is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            lat_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q     <= bus.cmd_address;
                        wdata_q    <= bus.cmd_wdata;
                        is_write_q <= bus.cmd_write;
                        write_q    <= bus.cmd_write;
                        read_q     <= !bus.cmd_write;
                        state_q    <= BUS;
                    end
                end
                BUS: begin
                    if (timeout) begin
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else if (!bus.waitrequest) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (is_write_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b0;
                            state_q     <= RESP;
                        end else if (READ_LATENCY == 0) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= bus.readdata;
                            rsp_err_q   <= 1'b0;
                            state_q     <= RESP;
                        end else begin
                            lat_cnt_q <= LAT_LOAD;
                            state_q   <= RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    if (lat_cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus.readdata;
                        rsp_err_q   <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.address   = addr_q;
    assign bus.writedata = wdata_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_avmm_pio_master.sv
// Self-checking bench for avmm_pio_master: directed cases plus randomized
// commands, with the bench acting as the PIO slave and predicting each
// response's content and arrival cycle from the transfer rules.
module tb_avmm_pio_master;
    import avmm_pio_pkg::*;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 1;
    localparam int unsigned TO = 8;
`ifdef AVMM_PIO_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cycle = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [DW-1:0] mem [4];

    avmm_pio_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    avmm_pio_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .READ_LATENCY   (RL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One complete command: present, wait for acceptance, act as the slave,
    // and check strobes, response content, response cycle and handshake.
    task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int stalls, input int rdy_delay, output int acc_cyc);
        int            waited;
        int            exp_strobe;
        int            exp_rsp_k;
        int            rsp_k;
        bit            done;
        bit            to;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] rd_val;

        to       = TO_EN && (stalls >= int'(TO));
        rd_val   = mem[a];
        exp_data = (wr || to) ? '0 : rd_val;
        exp_strobe = to ? int'(TO) : stalls + 1;
        exp_rsp_k  = to ? int'(TO) + 1 : stalls + 2 + (wr ? 0 : int'(RL));
        if (wr && !to) mem[a] = d;

        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = wr;
        bus.cmd_address = a;
        bus.cmd_wdata   = d;
        waited = 0;
        while (!bus.cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.cmd_ready) check_eq("cmd_accept_bound", 0, 1);
        acc_cyc = int'(cycle);
        @(posedge clk); #1;
        // Later command changes must be ignored.
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = ~wr;
        bus.cmd_address = $urandom;
        bus.cmd_wdata   = $urandom;

        rsp_k = 0;
        done  = 1'b0;
        for (int k = 1; k <= 300 && !done; k++) begin
            bus.waitrequest = (k <= stalls);
            bus.readdata    = (!wr && k == stalls + 1 + int'(RL)) ? rd_val : DW'($urandom);
            if (k <= exp_strobe) begin
                check_eq("write_strobe", bus.write, wr);
                check_eq("read_strobe", bus.read, !wr);
                check_eq("address", bus.address, a);
                if (wr) check_eq("writedata", bus.writedata, d);
            end else begin
                check_eq("strobe_low", bus.read | bus.write, 0);
            end
            check_eq("cmd_ready_busy", bus.cmd_ready, 0);
            if (bus.rsp_valid) begin
                if (rsp_k == 0) begin
                    rsp_k = k;
                    check_eq("rsp_cycle", k, exp_rsp_k);
                end
                check_eq("rsp_data", bus.rsp_data, exp_data);
                check_eq("rsp_err", bus.rsp_err, to);
                bus.rsp_ready = (k - rsp_k >= rdy_delay);
                if (bus.rsp_ready) done = 1'b1;
            end else begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready   = 1'b0;
        bus.waitrequest = 1'b0;
        if (!done) check_eq("rsp_handshake_bound", 0, 1);
        check_eq("single_rsp", bus.rsp_valid, 0);
        check_eq("cmd_ready_idle", bus.cmd_ready, 1);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int acc [3];
        int a0;

        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_address = '0;
        bus.cmd_wdata   = '0;
        bus.waitrequest = 1'b0;
        bus.readdata    = '0;
        bus.rsp_ready   = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = $urandom;

        // Reset values.
        #12;
        check_eq("rst_read", bus.read, 0);
        check_eq("rst_write", bus.write, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_err", bus.rsp_err, 0);
        check_eq("rst_rsp_data", bus.rsp_data, 0);
        check_eq("rst_address", bus.address, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);

        // Directed: zero-wait write to the control register.
        run_txn(1'b1, ADDR_CTRL, 32'hA5A5_0012, 0, 0, a0);
        // Directed: read returning 0xC3.
        mem[1] = 32'h0000_00C3;
        run_txn(1'b0, 2'd1, 32'h0, 0, 0, a0);
        // Directed: write stalled for 4 cycles.
        run_txn(1'b1, 2'd2, 32'h1234_5678, 4, 0, a0);
        // Directed: back-to-back with rsp_ready high.
        run_txn(1'b1, 2'd3, 32'hDEAD_BEEF, 0, 0, acc[0]);
        run_txn(1'b0, 2'd3, 32'h0, 0, 0, acc[1]);
        run_txn(1'b1, 2'd0, 32'h0BAD_F00D, 0, 0, acc[2]);
        check_eq("b2b_gap_wr", acc[1] - acc[0], 3);
        check_eq("b2b_gap_rd", acc[2] - acc[1], 3 + RL);
        // Directed: response held off for 10 cycles.
        run_txn(1'b0, 2'd0, 32'h0, 1, 10, a0);

`ifdef AVMM_PIO_MASTER_TIMEOUT_EN
        // Directed: waitrequest stuck high on a write and a read.
        run_txn(1'b1, 2'd1, 32'hCAFE_0001, 30, 0, a0);
        run_txn(1'b0, 2'd2, 32'h0, 30, 1, a0);
`endif

        // Randomized commands.
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), a0);
        end

        // Reset in the middle of a stalled transfer.
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = 1'b1;
        bus.cmd_address = 2'd2;
        bus.cmd_wdata   = 32'h5555_AAAA;
        bus.waitrequest = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check_eq("pre_reset_write", bus.write, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset_write", bus.write, 0);
        check_eq("async_reset_read", bus.read, 0);
        @(posedge clk); #3;
        reset = 1'b0;
        bus.waitrequest = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("no_rsp_after_reset", bus.rsp_valid, 0);
            check_eq("idle_after_reset", bus.cmd_ready, 1);
        end
        bus.rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avmm_pio_master.md
# avmm_pio_master

Avalon-MM initiator that drives the register ports of the PIO slave on behalf of a simple command/response stream. It issues one single-beat read or write at a time: it honours `waitrequest` and a fixed read latency, and returns write completions or read data on a valid/ready response port. It sits between the key/switch or test-sequencer logic and the PIO slave, so that the slave can be driven without the HPS bridge.

## Interface
Parameters:
- `ADDR_W`, default 2: Avalon address width.
- `DATA_W`, default 32: data width for commands, Avalon transfers and responses.
- `READ_LATENCY`, default 1: cycles from the read acceptance edge to valid `readdata`; legal range 0–7.
- `TIMEOUT_CYCLES`, default 255: waitrequest stall limit; used only when `AVMM_PIO_MASTER_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when both valid and ready are high.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_address`  in  ADDR_W  target register.
- `cmd_wdata`  in  DATA_W  write data.
- `address`  out  ADDR_W  Avalon address.
- `read`  out  1  Avalon read strobe.
- `write`  out  1  Avalon write strobe.
- `writedata`  out  DATA_W  Avalon write data.
- `waitrequest`  in  1  slave stall; tie to 0 for slaves without it.
- `readdata`  in  DATA_W  slave read data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  DATA_W  read data; 0 for writes.
- `rsp_err`  out  1  transfer timed out.

## Operation
- FSM states: IDLE, BUS, RWAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: register address, wdata and direction, then go to BUS.
- BUS:
  - Drive `address`, `writedata`, and exactly one of `read`/`write`, all from registers.
  - Hold every signal stable while `waitrequest`=1.
  - On the first cycle with `waitrequest`=0 the transfer is accepted:
    - write → RESP with `rsp_data`=0, `rsp_err`=0;
    - read with `READ_LATENCY`=0 → capture `readdata` that cycle, go to RESP;
    - read with `READ_LATENCY`>0 → go to RWAIT.
- RWAIT:
  - `read`=0; a down-counter loaded with `READ_LATENCY`-1 counts down.
  - At 0: capture `readdata`, go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_err` are held.
  - On `rsp_ready`=1 → IDLE.
  - `cmd_ready` is 0, so a new command is not accepted in the same cycle.
- Only one transfer is outstanding at a time. `cmd_ready` is 0 in every state except IDLE.
- Command fields are sampled only at acceptance; later changes have no effect.
- Reset values: all outputs 0 and state IDLE, except `cmd_ready`, which is 1 once the block is in IDLE.
- Reset asserted mid-transfer: the transfer is abandoned, strobes drop asynchronously, and no response is produced.

## Timing
- Command accepted at edge N → `read`/`write` high from cycle N+1.
- Write with zero wait states: `rsp_valid` in cycle N+2.
- Read with zero wait states: `rsp_valid` in cycle N+2+`READ_LATENCY`.
- Each cycle of `waitrequest`=1 adds one cycle to either path.
- Minimum command-to-command spacing is 3 cycles (IDLE, BUS, RESP) with `rsp_ready` held high.
- `cmd_valid` and `rsp_ready` arriving together in RESP: only the response completes; the command is taken in the next IDLE cycle.

## Configuration
- Macro `AVMM_PIO_MASTER_TIMEOUT_EN`.
- Defined:
  - A stall counter counts the consecutive BUS cycles with `waitrequest`=1.
  - When the count reaches `TIMEOUT_CYCLES`, strobes drop on the next edge, the FSM goes to RESP with `rsp_err`=1 and `rsp_data`=0, and no RWAIT follows.
  - The counter clears on entry to BUS.
- Undefined:
  - No counter; BUS waits indefinitely.
  - `rsp_err` is tied to 0.

## Structure
- Shared package `avmm_pio_pkg` holds:
  - the state enum (IDLE, BUS, RWAIT, RESP);
  - the PIO register address constants (`ADDR_CTRL`=2'b00, the other addresses reserved);
  - the `DATA_W` default.
- One sub-module is natural: `avmm_watchdog`, the saturating stall counter with clear/enable/expired ports, instantiated only under the macro.
- Counter widths are derived with `$clog2`.

## Test plan
- Write, addr 0, data 0xA5A5_0012, `waitrequest`=0 → `write`=1 for exactly 1 cycle with matching address and data; `rsp_valid` 2 cycles after acceptance; `rsp_data`=0, `rsp_err`=0.
- Read with `READ_LATENCY`=1 and slave returning 0x0000_00C3 → `read` pulses 1 cycle; `rsp_data`=0xC3 at cycle N+3.
- Write with `waitrequest` high for 4 cycles → strobe, address and data stable for 5 cycles; one response only.
- Back-to-back: 3 commands with `rsp_ready` held high → 3 responses, in order, each 3 cycles apart.
- `rsp_ready` held low for 10 cycles → `cmd_ready` stays 0 and no new Avalon strobe is issued.
- With macro, `TIMEOUT_CYCLES`=8, `waitrequest` stuck high → strobe drops after 8 stall cycles; `rsp_err`=1. Then `reset` pulsed mid-BUS on the next command → `read`/`write`=0 immediately and no response.
